keypad_port: RTL and testbench
==============================

Name: keypad_port

Overview:
- Memory-mapped CPU peripheral directly downstream of the keypad block.
- Takes the latched key code and its press strobe from the slow keypad domain and resynchronises them into the system clock domain.
- Queues each press in a small FIFO and presents data, status and control registers to the 6502 bus, with a level interrupt while keys are pending.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..8 (the count field is 4 bits).
- SETTLE_CYC, 4, clk cycles between a synchronised press rising edge and sampling of the synchronised key code; range 1..15.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- key  in  8  latched key code from the keypad block; asynchronous to clk.
- key_press  in  1  keypad press strobe; the keypad block's valid_press net is exported for this. Asynchronous to clk.
- cs  in  1  chip select; one bus access per clk cycle while high.
- addr  in  1  0 = DATA, 1 = STATUS/CTRL.
- we  in  1  1 = write, 0 = read.
- wdata  in  8  write data.
- rdata  out  8  read data; combinational from addr and register state.
- irq  out  1  interrupt request, active high, level.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty; rd/wr pointers and count = 0.
  - overflow = 0, irq_en = 0, synchroniser flops = 0, FSM = IDLE.
  - Resulting outputs: irq = 0, rdata = 0x00 for either addr.
  - Reset asserted mid-operation discards any pending capture and all FIFO content.
- Synchronisation:
  - key_press passes through 2 flops, then a third flop for edge detect; rise = sync & ~prev.
  - key passes through 2 flops (key_s). It is stable for ms around a press, so a multi-bit sync is safe once settled.
- Capture FSM:
  - IDLE: on rise, load settle counter with SETTLE_CYC and go to WAIT.
  - WAIT: decrement each cycle. Further rises are ignored. At 0, go to PUSH.
  - PUSH: issue a one-cycle push of key_s, then go to IDLE.
  - Minimum latency from the key_press edge to the FIFO entry being visible in STATUS is SETTLE_CYC + 4 cycles.
- FIFO:
  - Push when full with no simultaneous pop: entry dropped, overflow set (sticky).
  - Push and pop in the same cycle:
    - Both are performed and count is unchanged.
    - Full plus simultaneous pop: the push is accepted, no overflow.
    - Empty plus push: the pop is ignored and the push is accepted.
  - Pointers wrap modulo DEPTH.
- Bus reads (cs=1, we=0):
  - addr 0: rdata = head entry, or 0x00 if empty. The FIFO pops on this clk edge if not empty.
  - addr 1: rdata = {count[3:0], irq_en, overflow, full, not_empty} in bits [7:0]. No side effects.
  - rdata must still be driven when cs=0.
- Bus writes (cs=1, we=1):
  - addr 0: ignored.
  - addr 1, bit0: irq_en = wdata[0].
  - addr 1, bit6 = 1: clear overflow.
  - addr 1, bit7 = 1: flush. FIFO empty, overflow cleared. Flush beats a same-cycle push, and that push is dropped without setting overflow.
  - Other bits: ignored.
- Interrupt: irq = irq_en & not_empty. It derives only from registered state, so it is glitch-free.

Decomposition:
- Shared package keypad_pkg:
  - Register offsets ADDR_DATA=0, ADDR_STAT=1.
  - Status bit indices: NE=0, FULL=1, OVF=2, IEN=3, CNT=7:4.
  - Control bit indices: IEN=0, OVF_CLR=6, FLUSH=7.
  - FSM state encoding IDLE/WAIT/PUSH.
- Sub-module keypad_fifo: synchronous FIFO (DEPTH×8), with push/pop/flush inputs and data/count/full/empty/overflow outputs.
- The synchroniser, capture FSM and bus decode stay in keypad_port.

Test Plan:
- Reset, then read STATUS → 0x00, read DATA → 0x00, irq=0, no pop.
- key=0x35, key_press pulse 100 cycles → after ≤ SETTLE_CYC+4 cycles STATUS=0x11; DATA read → 0x35; STATUS then 0x00.
- Write CTRL 0x01, then one press of key 0x0A → irq rises with not_empty. DATA read → 0x0A, irq falls the next cycle, STATUS=0x08.
- 9 presses of 0x01..0x09 with no reads (DEPTH=8) → STATUS=0x87 (count 8, ovf, full, ne). Reads return 0x01..0x08, then 0x00. Write CTRL 0x40 → ovf=0.
- Full FIFO, DATA read coinciding with the PUSH cycle → count stays 8, overflow stays 0, the new key becomes the tail entry.
- Three entries queued, write CTRL 0x80 in the same cycle as a push → STATUS=0x00, overflow=0. rst_n pulsed during WAIT → no entry is pushed afterwards.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad CPU port: register map, bit positions
// and capture FSM encoding.
package keypad_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int ST_NE     = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_IEN    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 7;

  localparam int CT_IEN     = 0;
  localparam int CT_OVF_CLR = 6;
  localparam int CT_FLUSH   = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PUSH = 2'd2
  } cap_state_e;

endpackage

// File: rtl/keypad_fifo.sv
// Synchronous DEPTH x 8 key FIFO with sticky overflow and flush.
module keypad_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic       ovf_clr_i,
  output logic [7:0] head_o,
  output logic [3:0] count_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic          ovf_q;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o    = (count_q == 4'd0);
  assign full_o     = (count_q == 4'(DEPTH));
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign head_o     = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push_i && !do_push) ovf_q <= 1'b1;
      else if (ovf_clr_i)     ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/keypad_port.sv
// 6502-bus port for the keypad: resynchronises key/press, queues presses in
// a FIFO and exposes DATA and STATUS/CTRL registers plus a level interrupt.
module keypad_port
  import keypad_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       key_press,
  input  logic       cs,
  input  logic       addr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  logic       press_s1_q, press_s2_q, press_prev_q;
  logic [7:0] key_s1_q, key_s2_q;
  logic       rise;

  cap_state_e state_q;
  logic [3:0] settle_q;
  logic       push_q;

  logic       irq_en_q, irq_en_d;
  logic       rd_acc, wr_acc, pop, ctrl_wr, flush, ovf_clr;
  logic [7:0] head, status;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic       ctrl_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_s1_q   <= 1'b0;
      press_s2_q   <= 1'b0;
      press_prev_q <= 1'b0;
      key_s1_q     <= 8'h00;
      key_s2_q     <= 8'h00;
    end else begin
      press_s1_q   <= key_press;
      press_s2_q   <= press_s1_q;
      press_prev_q <= press_s2_q;
      key_s1_q     <= key;
      key_s2_q     <= key_s1_q;
    end
  end

  assign rise = press_s2_q & ~press_prev_q;

  // The key bus is only sampled after the settle delay, once all bits agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= 4'd0;
      push_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          push_q <= 1'b0;
          if (rise) begin
            settle_q <= 4'(SETTLE_CYC);
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_q <= 4'd1) begin
            settle_q <= 4'd0;
            push_q   <= 1'b1;
            state_q  <= S_PUSH;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        S_PUSH: begin
          push_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          push_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Bus: every cycle with cs high is exactly one access; a DATA read pops.
  assign rd_acc  = cs & ~we;
  assign wr_acc  = cs & we;
  assign pop     = rd_acc & (addr == ADDR_DATA);
  assign ctrl_wr = wr_acc & (addr == ADDR_STAT);
  assign flush   = ctrl_wr & wdata[CT_FLUSH];
  assign ovf_clr = ctrl_wr & wdata[CT_OVF_CLR];
  assign irq_en_d = ctrl_wr ? wdata[CT_IEN] : irq_en_q;
  assign ctrl_unused = ^wdata[5:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_en_q <= 1'b0;
    else        irq_en_q <= irq_en_d;
  end

  keypad_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_q),
    .push_data_i (key_s2_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .ovf_clr_i   (ovf_clr),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .overflow_o  (overflow)
  );

  always_comb begin
    status                        = 8'h00;
    status[ST_NE]                 = ~empty;
    status[ST_FULL]               = full;
    status[ST_OVF]                = overflow;
    status[ST_IEN]                = irq_en_q;
    status[ST_CNT_HI:ST_CNT_LO]   = count;
  end

  assign rdata = (addr == ADDR_DATA) ? (empty ? 8'h00 : head) : status;
  assign irq   = irq_en_q & ~empty;

endmodule

// File: tb/tb_keypad_port.sv
// Bench for keypad_port: reset block, bus/press driver tasks, a table of
// directed vectors, corner-case sequences and a randomized model-checked run.
module tb_keypad_port;

  localparam int DEPTH  = 8;
  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + 4;

  logic       clk, rst_n;
  logic [7:0] key;
  logic       key_press, cs, addr, we;
  logic [7:0] wdata, rdata;
  logic       irq;

  keypad_port #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_press (key_press),
    .cs        (cs),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  logic [7:0] exp_q[$];
  bit         m_ovf, m_ien;

  function automatic logic [7:0] model_status();
    int n;
    n = exp_q.size();
    return {4'(n), m_ien, m_ovf, (n == DEPTH), (n != 0)};
  endfunction

  // ---------------- drivers ----------------
  task automatic bus_rd(input logic a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] dat);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wdata = dat;
    @(posedge clk);
    #1 cs = 1'b0; we = 1'b0;
  endtask

  // mode 0: plain press; 1: DATA read in the push cycle; 2: CTRL write in the push cycle
  task automatic press(input logic [7:0] k, input int mode, input logic [7:0] wd,
                       output logic [7:0] d);
    d = 8'h00;
    repeat (4) @(negedge clk);
    key = k; key_press = 1'b1;
    if (mode == 0) begin
      repeat (LAT) @(posedge clk);
      #1 key_press = 1'b0;
    end else begin
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      cs = 1'b1; we = (mode == 2); addr = (mode == 2); wdata = wd;
      #1 d = rdata;
      @(posedge clk);
      #1 cs = 1'b0; we = 1'b0; key_press = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef enum int {V_PRESS, V_RD, V_WR, V_IRQ} vop_e;
  typedef struct {
    vop_e       op;
    logic       a;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input vop_e op, input logic a, input logic [7:0] d,
                              input logic [7:0] e);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.e = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] d;
    int         r;
    logic [7:0] k, wd;
    logic       wa;

    rst_n = 1'b0; key = 8'h00; key_press = 1'b0;
    cs = 1'b0; addr = 1'b0; we = 1'b0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    add(V_RD, 1, 0, 8'h00); add(V_RD, 0, 0, 8'h00); add(V_IRQ, 0, 0, 8'h00);
    add(V_RD, 1, 0, 8'h00);
    add(V_PRESS, 0, 8'h35, 0); add(V_RD, 1, 0, 8'h11); add(V_RD, 0, 0, 8'h35);
    add(V_RD, 1, 0, 8'h00);
    add(V_WR, 1, 8'h01, 0); add(V_PRESS, 0, 8'h0A, 0); add(V_IRQ, 0, 0, 8'h01);
    add(V_RD, 1, 0, 8'h19); add(V_RD, 0, 0, 8'h0A); add(V_IRQ, 0, 0, 8'h00);
    add(V_RD, 1, 0, 8'h08);
    add(V_WR, 1, 8'h00, 0);
    for (int i = 1; i <= 9; i++) add(V_PRESS, 0, 8'(i), 0);
    add(V_RD, 1, 0, 8'h87);
    for (int i = 1; i <= 8; i++) add(V_RD, 0, 0, 8'(i));
    add(V_RD, 0, 0, 8'h00); add(V_RD, 1, 0, 8'h04);
    add(V_WR, 1, 8'h40, 0); add(V_RD, 1, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        V_PRESS: press(vecs[i].d, 0, 8'h00, d);
        V_WR:    bus_wr(vecs[i].a, vecs[i].d);
        V_RD: begin
          bus_rd(vecs[i].a, d);
          check($sformatf("vec%0d_rd%0d", i, vecs[i].a), d, vecs[i].e);
        end
        default: begin
          @(negedge clk);
          check($sformatf("vec%0d_irq", i), {7'b0, irq}, vecs[i].e);
        end
      endcase
    end

    // full FIFO with a DATA read landing on the push cycle
    for (int i = 0; i < DEPTH; i++) press(8'h11 + 8'(i), 0, 8'h00, d);
    press(8'hAA, 1, 8'h00, d);
    check("full_pop_head", d, 8'h11);
    bus_rd(1, d); check("full_pop_status", d, 8'h83);
    for (int i = 1; i < DEPTH; i++) begin
      bus_rd(0, d); check($sformatf("full_pop_data%0d", i), d, 8'h11 + 8'(i));
    end
    bus_rd(0, d); check("full_pop_tail", d, 8'hAA);
    bus_rd(1, d); check("full_pop_empty", d, 8'h00);

    // flush written in the same cycle as a push
    for (int i = 0; i < 3; i++) press(8'h21 + 8'(i), 0, 8'h00, d);
    bus_rd(1, d); check("pre_flush_status", d, 8'h31);
    press(8'h24, 2, 8'h80, d);
    bus_rd(1, d); check("flush_status", d, 8'h00);
    bus_rd(0, d); check("flush_data", d, 8'h00);

    // reset asserted while the capture FSM is waiting
    press(8'h55, 0, 8'h00, d);
    bus_rd(1, d); check("pre_rst_status", d, 8'h11);
    @(negedge clk);
    key = 8'h66; key_press = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    key_press = 1'b0; rst_n = 1'b0; addr = 1'b1;
    #1 check("rst_rdata_stat", rdata, 8'h00);
    addr = 1'b0;
    #1 check("rst_rdata_data", rdata, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * LAT) @(negedge clk);
    bus_rd(1, d); check("post_rst_status", d, 8'h00);
    bus_rd(0, d); check("post_rst_data", d, 8'h00);

    // randomized run against the queue model
    do_reset();
    exp_q.delete(); m_ovf = 0; m_ien = 0;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        k = 8'($urandom_range(0, 255));
        press(k, 0, 8'h00, d);
        if (exp_q.size() == DEPTH) m_ovf = 1;
        else exp_q.push_back(k);
      end else if (r <= 6) begin
        bus_rd(0, d);
        check("rnd_data", d, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00);
      end else if (r == 7) begin
        bus_rd(1, d);
        check("rnd_status", d, model_status());
      end else begin
        wa = 1'($urandom_range(0, 3) != 0);
        wd = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) wd[7] = 1'b0;
        bus_wr(wa, wd);
        if (wa) begin
          m_ien = wd[0];
          if (wd[7]) begin
            exp_q.delete();
            m_ovf = 0;
          end else if (wd[6]) begin
            m_ovf = 0;
          end
        end
      end
      check("rnd_irq", {7'b0, irq}, {7'b0, (m_ien && exp_q.size() != 0)});
    end
    bus_rd(1, d); check("rnd_final_status", d, model_status());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
